// File: rtl/multi_debounce.sv
// N-channel input conditioner: per-channel synchroniser, debounce counter and
// edge ticks, with an optional atomic group that only updates as a whole word.
module multi_debounce #(
    parameter int                  CHANNELS      = 8,
    parameter int                  STABLE_CYCLES = 1300000,
    parameter int                  SYNC_STAGES   = 2,
    parameter logic [CHANNELS-1:0] GROUP_MASK    = '0,
    parameter logic [CHANNELS-1:0] RESET_LEVEL   = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] raw_in,
    output logic [CHANNELS-1:0] db_level,
    output logic [CHANNELS-1:0] db_rise,
    output logic [CHANNELS-1:0] db_fall,
    output logic                group_update,
    output logic [CHANNELS-1:0] busy
);

    localparam int             CW      = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;
    logic [CHANNELS-1:0][CW-1:0]          cnt_q, cnt_d;
    logic [CHANNELS-1:0]                  level_q, level_d;
    logic [CHANNELS-1:0]                  rise_q, rise_d;
    logic [CHANNELS-1:0]                  fall_q, fall_d;
    logic [CHANNELS-1:0]                  gsamp_q, gsamp_d;
    logic [CW-1:0]                        gcnt_q, gcnt_d;
    logic                                 gupd_q, gupd_d;

    logic [CHANNELS-1:0] sync_s;
    logic [CHANNELS-1:0] g_s;
    logic [CHANNELS-1:0] glevel_s;
    logic [CHANNELS-1:0] busy_s;

    assign sync_s   = sync_q[SYNC_STAGES-1];
    assign g_s      = sync_s & GROUP_MASK;
    assign glevel_s = level_q & GROUP_MASK;

    // Next-state: synchroniser shift, independent counters, then the group.
    always_comb begin
        sync_d  = sync_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        gsamp_d = gsamp_q;
        gcnt_d  = gcnt_q;
        gupd_d  = 1'b0;

        sync_d[0] = raw_in;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end

        for (int i = 0; i < CHANNELS; i++) begin
            if (GROUP_MASK[i]) begin
                cnt_d[i] = '0;
            end else if (sync_s[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                level_d[i] = ~level_q[i];
                rise_d[i]  = ~level_q[i];
                fall_d[i]  = level_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end

        // Any movement inside the group restarts the shared count.
        if (g_s != gsamp_q) begin
            gsamp_d = g_s;
            gcnt_d  = '0;
        end else if (gsamp_q != glevel_s) begin
            if (gcnt_q == CNT_MAX) begin
                level_d = (level_d & ~GROUP_MASK) | gsamp_q;
                rise_d  = rise_d | (gsamp_q & ~level_q);
                fall_d  = fall_d | (level_q & GROUP_MASK & ~gsamp_q);
                gupd_d  = 1'b1;
                gcnt_d  = '0;
            end else begin
                gcnt_d = gcnt_q + CW'(1);
            end
        end else begin
            gcnt_d = '0;
        end
    end

    // Pending-value indication, derived from registered state only.
    always_comb begin
        busy_s = (sync_s ^ level_q) & ~GROUP_MASK;
        if ((gsamp_q != glevel_s) || (g_s != gsamp_q)) begin
            busy_s = busy_s | GROUP_MASK;
        end else begin
            busy_s = busy_s;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= RESET_LEVEL;
            end
            cnt_q   <= '0;
            level_q <= RESET_LEVEL;
            rise_q  <= '0;
            fall_q  <= '0;
            gsamp_q <= RESET_LEVEL & GROUP_MASK;
            gcnt_q  <= '0;
            gupd_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            gsamp_q <= gsamp_d;
            gcnt_q  <= gcnt_d;
            gupd_q  <= gupd_d;
        end
    end

    assign db_level     = level_q;
    assign db_rise      = rise_q;
    assign db_fall      = fall_q;
    assign group_update = gupd_q;
    assign busy         = busy_s;

endmodule
